// File: rtl/peripheral_wb_arbiter_rr.sv
// peripheral_wb_arbiter_rr
// -------------------------
// Round-robin arbiter sharing one Wishbone B3 slave between NUM_MASTERS
// masters (processor and DMA masters in front of the shared MPRAM).
//
// A grant covers a whole bus cycle. It is taken when the owner raises cyc and
// is released only when the owner drops cyc, so classic cycles and CTI bursts
// (constant or incrementing, any BTE) are never split. CTI/BTE are forwarded
// untouched, and an end-of-burst ack does not release the grant.
//
// An ack watchdog counts consecutive stalled strobe cycles. When the count
// reaches TIMEOUT it answers the owner with a one-cycle err, masks the slave
// strobe for that cycle and keeps the grant. The owner decides what to do next.
//
// Ports
//   wb_clk_i, wb_rst_i     clock, synchronous active-high reset
//   m_*_i                  master request bundles; master k uses slice k
//   m_dat_o                slave read data, broadcast to every master
//   m_ack_o, m_err_o       per-master responses, gated by the grant
//   s_*_o                  request of the granted master (all zero when idle)
//   s_dat_i/ack_i/err_i    slave response
//   grant_o                registered one-hot grant; zero when idle
module peripheral_wb_arbiter_rr #(
    parameter int NUM_MASTERS = 4,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    // master side
    input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS-1:0]      m_cyc_i,
    input  logic [NUM_MASTERS-1:0]      m_stb_i,
    input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
    output logic [DW-1:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,
    // slave side
    output logic [AW-1:0]               s_adr_o,
    output logic [DW-1:0]               s_dat_o,
    output logic [DW/8-1:0]             s_sel_o,
    output logic                        s_we_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    output logic [2:0]                  s_cti_o,
    output logic [1:0]                  s_bte_o,
    input  logic [DW-1:0]               s_dat_i,
    input  logic                        s_ack_i,
    input  logic                        s_err_i,
    // arbitration status
    output logic [NUM_MASTERS-1:0]      grant_o
);

    localparam int SW = DW / 8;
    // keep the index at least one bit wide so NUM_MASTERS=1 still elaborates
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t          state;
    logic [IW-1:0]   owner;      // index of the granted master, valid in OWN
    logic [IW-1:0]   rr_ptr;     // highest-priority master for the next pick
    logic [15:0]     wd_cnt;     // consecutive stalled strobe cycles

    logic [IW-1:0]   rel_ptr;    // pointer after the current owner releases
    logic [IW-1:0]   cand_idle;  // pick when leaving IDLE
    logic [IW-1:0]   cand_rel;   // pick on release, scanned from rel_ptr
    logic            owner_cyc;
    logic            wd_fire;
    logic            wd_clr;

    // First requester scanning ptr, ptr+1, ... modulo NUM_MASTERS. The scan
    // runs from the farthest offset to the nearest so the nearest hit wins.
    function automatic logic [IW-1:0] rr_pick(input logic [IW-1:0]          ptr,
                                              input logic [NUM_MASTERS-1:0] req);
        int idx;
        rr_pick = ptr;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_MASTERS)
                idx = idx - NUM_MASTERS;
            if (req[idx])
                rr_pick = IW'(idx);
        end
    endfunction

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IW-1:0] idx);
        onehot = NUM_MASTERS'(1) << idx;
    endfunction

    // ------------------------------------------------------------------
    // Arbitration decode
    // ------------------------------------------------------------------
    always_comb begin
        rel_ptr   = (int'(owner) == NUM_MASTERS - 1) ? '0 : owner + IW'(1);
        cand_idle = rr_pick(rr_ptr, m_cyc_i);
        // the releasing master has cyc low, so it falls to lowest priority
        cand_rel  = rr_pick(rel_ptr, m_cyc_i);
        owner_cyc = |(m_cyc_i & grant_o);
    end

    // ------------------------------------------------------------------
    // Request mux: AND-OR over the one-hot grant, so an idle arbiter
    // presents an all-zero request to the slave.
    // ------------------------------------------------------------------
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (grant_o[k]) begin
                s_adr_o = s_adr_o | m_adr_i[k*AW +: AW];
                s_dat_o = s_dat_o | m_dat_i[k*DW +: DW];
                s_sel_o = s_sel_o | m_sel_i[k*SW +: SW];
                s_we_o  = s_we_o  | m_we_i[k];
                s_cti_o = s_cti_o | m_cti_i[k*3 +: 3];
                s_bte_o = s_bte_o | m_bte_i[k*2 +: 2];
            end
        end
    end

    // ------------------------------------------------------------------
    // Watchdog and handshake gating
    // ------------------------------------------------------------------
    // Fires in the (TIMEOUT+1)th consecutive stalled cycle. Masking stb in
    // that cycle also clears the counter through wd_clr.
    assign wd_fire = (state == OWN) && (wd_cnt == 16'(TIMEOUT));
    assign s_cyc_o = owner_cyc;
    assign s_stb_o = (|(m_stb_i & grant_o)) & ~wd_fire;
    assign wd_clr  = ~s_stb_o | s_ack_i | s_err_i;

    assign m_dat_o = s_dat_i;
    assign m_ack_o = grant_o & {NUM_MASTERS{s_ack_i}};
    // a real ack in the fire cycle completes the transfer; the timeout err
    // is dropped so the master never sees ack and err together from us
    assign m_err_o = grant_o & {NUM_MASTERS{s_err_i | (wd_fire & ~s_ack_i)}};

    // ------------------------------------------------------------------
    // Grant FSM
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            owner   <= '0;
            rr_ptr  <= '0;
            grant_o <= '0;
            wd_cnt  <= '0;
        end else begin
            wd_cnt <= wd_clr ? 16'd0 : wd_cnt + 16'd1;
            case (state)
                IDLE: begin
                    if (|m_cyc_i) begin
                        state   <= OWN;
                        owner   <= cand_idle;
                        grant_o <= onehot(cand_idle);
                    end
                end
                OWN: begin
                    // hold through bursts regardless of cti/bte or other
                    // requesters; only the owner's cyc drop releases
                    if (!owner_cyc) begin
                        rr_ptr <= rel_ptr;
                        if (|m_cyc_i) begin
                            owner   <= cand_rel;
                            grant_o <= onehot(cand_rel);
                        end else begin
                            state   <= IDLE;
                            grant_o <= '0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_o <= '0;
                end
            endcase
        end
    end

endmodule
